// File: rtl/lsu_tlbrd_pipe.sv
// TLB tag/data diagnostic-read return path: issue, parity check, format, and a
// credit-protected result FIFO with saturating error counters and a first-error log.
module lsu_tlbrd_pipe #(
    parameter int TAG_W  = 59,
    parameter int DATA_W = 43,
    parameter int NTHR   = 4,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = 8,
    parameter int TID_W  = (NTHR > 1) ? $clog2(NTHR) : 1,
    parameter logic [TAG_W-1:0]  TAG_PMASK  = {TAG_W{1'b1}},
    parameter logic [DATA_W-1:0] DATA_PMASK = {DATA_W{1'b1}}
) (
    input  logic              rclk,
    input  logic              rst,
    input  logic              rd_req_vld,
    input  logic              rd_req_sel,
    input  logic [TID_W-1:0]  rd_req_tid,
    output logic              rd_req_rdy,
    output logic              tlb_rd_en,
    output logic              tlb_rd_sel,
    input  logic [TAG_W-1:0]  tlb_rd_tte_tag,
    input  logic              tlb_rd_tte_tag_parity,
    input  logic [DATA_W-1:0] tlb_rd_tte_data,
    input  logic              tlb_rd_tte_data_parity,
    input  logic              par_chk_en,
    output logic              rsp_vld,
    input  logic              rsp_rdy,
    output logic [63:0]       rsp_data,
    output logic [TID_W-1:0]  rsp_tid,
    output logic              rsp_perr,
    output logic [CNT_W-1:0]  tag_perr_cnt,
    output logic [CNT_W-1:0]  data_perr_cnt,
    output logic              perr_first_vld,
    output logic [TID_W-1:0]  perr_first_tid,
    input  logic              err_cnt_clr
);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 3) + 1;

    logic              s1_vld_q, s1_vld_d, s1_sel_q, s1_sel_d;
    logic [TID_W-1:0]  s1_tid_q, s1_tid_d;
    logic              s2_vld_q, s2_vld_d, s2_sel_q, s2_sel_d, s2_par_q, s2_par_d;
    logic [TID_W-1:0]  s2_tid_q, s2_tid_d;
    logic [62:0]       s2_word_q, s2_word_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]  fifo_cnt_q, fifo_cnt_d, occ;
    logic [CNT_W-1:0]  tag_cnt_q, tag_cnt_d, data_cnt_q, data_cnt_d;
    logic              first_vld_q, first_vld_d;
    logic [TID_W-1:0]  first_tid_q, first_tid_d;
    logic [63:0]       mem_data_q [DEPTH];
    logic [TID_W-1:0]  mem_tid_q  [DEPTH];

    logic [62:0] pmask;
    logic        perr, push, pop, tag_inc, data_inc, perr_push;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Credit uses registered occupancy only; a pop this cycle frees a slot next cycle.
    always_comb begin
        occ        = fifo_cnt_q + OCC_W'(s1_vld_q) + OCC_W'(s2_vld_q);
        rd_req_rdy = ~rst & (occ < OCC_W'(DEPTH));
        tlb_rd_en  = rd_req_vld & rd_req_rdy;
        tlb_rd_sel = tlb_rd_en & rd_req_sel;
    end

    always_comb begin
        pmask     = s2_sel_q ? 63'(DATA_PMASK) : 63'(TAG_PMASK);
        perr      = par_chk_en & (s2_par_q ^ (^(s2_word_q & pmask)));
        push      = s2_vld_q;
        rsp_vld   = (fifo_cnt_q != '0);
        pop       = rsp_vld & rsp_rdy;
        perr_push = push & perr;
        tag_inc   = perr_push & ~s2_sel_q;
        data_inc  = perr_push & s2_sel_q;
        rsp_data  = rsp_vld ? mem_data_q[rd_ptr_q] : '0;
        rsp_tid   = rsp_vld ? mem_tid_q[rd_ptr_q] : '0;
        rsp_perr  = rsp_data[63];
    end

    always_comb begin
        s1_vld_d  = tlb_rd_en;
        s1_sel_d  = tlb_rd_en ? rd_req_sel : s1_sel_q;
        s1_tid_d  = tlb_rd_en ? rd_req_tid : s1_tid_q;
        s2_vld_d  = s1_vld_q;
        s2_sel_d  = s2_sel_q;
        s2_tid_d  = s2_tid_q;
        s2_word_d = s2_word_q;
        s2_par_d  = s2_par_q;
        if (s1_vld_q) begin
            s2_sel_d  = s1_sel_q;
            s2_tid_d  = s1_tid_q;
            s2_word_d = s1_sel_q ? 63'(tlb_rd_tte_data) : 63'(tlb_rd_tte_tag);
            s2_par_d  = s1_sel_q ? tlb_rd_tte_data_parity : tlb_rd_tte_tag_parity;
        end

        wr_ptr_d   = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d   = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        fifo_cnt_d = fifo_cnt_q;
        if (push && !pop)      fifo_cnt_d = fifo_cnt_q + 1'b1;
        else if (!push && pop) fifo_cnt_d = fifo_cnt_q - 1'b1;

        // Clear beats a same-cycle increment but still records that error.
        tag_cnt_d  = tag_cnt_q;
        data_cnt_d = data_cnt_q;
        if (err_cnt_clr) begin
            tag_cnt_d  = CNT_W'(tag_inc);
            data_cnt_d = CNT_W'(data_inc);
        end else begin
            if (tag_inc && tag_cnt_q != '1)   tag_cnt_d  = tag_cnt_q + 1'b1;
            if (data_inc && data_cnt_q != '1) data_cnt_d = data_cnt_q + 1'b1;
        end

        first_vld_d = first_vld_q;
        first_tid_d = first_tid_q;
        if (err_cnt_clr) begin
            first_vld_d = perr_push;
            first_tid_d = perr_push ? s2_tid_q : '0;
        end else if (perr_push && !first_vld_q) begin
            first_vld_d = 1'b1;
            first_tid_d = s2_tid_q;
        end
    end

    always_ff @(posedge rclk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_sel_q    <= 1'b0;
            s1_tid_q    <= '0;
            s2_vld_q    <= 1'b0;
            s2_sel_q    <= 1'b0;
            s2_tid_q    <= '0;
            s2_word_q   <= '0;
            s2_par_q    <= 1'b0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            fifo_cnt_q  <= '0;
            tag_cnt_q   <= '0;
            data_cnt_q  <= '0;
            first_vld_q <= 1'b0;
            first_tid_q <= '0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_sel_q    <= s1_sel_d;
            s1_tid_q    <= s1_tid_d;
            s2_vld_q    <= s2_vld_d;
            s2_sel_q    <= s2_sel_d;
            s2_tid_q    <= s2_tid_d;
            s2_word_q   <= s2_word_d;
            s2_par_q    <= s2_par_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            fifo_cnt_q  <= fifo_cnt_d;
            tag_cnt_q   <= tag_cnt_d;
            data_cnt_q  <= data_cnt_d;
            first_vld_q <= first_vld_d;
            first_tid_q <= first_tid_d;
        end
    end

    // Storage needs no reset: the read side is masked while the FIFO is empty.
    always_ff @(posedge rclk) begin
        if (push && !rst) begin
            mem_data_q[wr_ptr_q] <= {perr, s2_word_q};
            mem_tid_q[wr_ptr_q]  <= s2_tid_q;
        end
    end

    assign tag_perr_cnt   = tag_cnt_q;
    assign data_perr_cnt  = data_cnt_q;
    assign perr_first_vld = first_vld_q;
    assign perr_first_tid = first_tid_q;
endmodule

// File: tb/tb_lsu_tlbrd_pipe.sv
// Directed bench for lsu_tlbrd_pipe with a one-cycle-latency TLB read model.
module tb_lsu_tlbrd_pipe;
    localparam int TAG_W = 59, DATA_W = 43, NTHR = 4, DEPTH = 4, CNT_W = 2, TID_W = 2;

    logic              rclk = 1'b0;
    logic              rst, rd_req_vld, rd_req_sel, rd_req_rdy, tlb_rd_en, tlb_rd_sel;
    logic [TID_W-1:0]  rd_req_tid, rsp_tid, perr_first_tid;
    logic              par_chk_en, rsp_vld, rsp_rdy, rsp_perr, perr_first_vld, err_cnt_clr;
    logic [63:0]       rsp_data;
    logic [CNT_W-1:0]  tag_perr_cnt, data_perr_cnt;

    logic [TAG_W-1:0]  tag_src = '0, tlb_tag = '0;
    logic [DATA_W-1:0] data_src = '0, tlb_data = '0;
    logic              tpar_src = 1'b0, dpar_src = 1'b0, tlb_tpar = 1'b0, tlb_dpar = 1'b0;

    int n_chk = 0, n_err = 0, n_acc = 0, n_rsp = 0, seen = 0;

    always #5 rclk = ~rclk;

    always @(posedge rclk) begin
        if (tlb_rd_en) begin
            tlb_tag  <= tag_src;
            tlb_tpar <= tpar_src;
            tlb_data <= data_src;
            tlb_dpar <= dpar_src;
        end
    end

    lsu_tlbrd_pipe #(.TAG_W(TAG_W), .DATA_W(DATA_W), .NTHR(NTHR), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .rclk(rclk), .rst(rst),
        .rd_req_vld(rd_req_vld), .rd_req_sel(rd_req_sel), .rd_req_tid(rd_req_tid),
        .rd_req_rdy(rd_req_rdy), .tlb_rd_en(tlb_rd_en), .tlb_rd_sel(tlb_rd_sel),
        .tlb_rd_tte_tag(tlb_tag), .tlb_rd_tte_tag_parity(tlb_tpar),
        .tlb_rd_tte_data(tlb_data), .tlb_rd_tte_data_parity(tlb_dpar),
        .par_chk_en(par_chk_en), .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy),
        .rsp_data(rsp_data), .rsp_tid(rsp_tid), .rsp_perr(rsp_perr),
        .tag_perr_cnt(tag_perr_cnt), .data_perr_cnt(data_perr_cnt),
        .perr_first_vld(perr_first_vld), .perr_first_tid(perr_first_tid),
        .err_cnt_clr(err_cnt_clr)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    // Drives one request for a single cycle; returns one cycle after acceptance.
    task automatic issue(input logic sel, input logic [TID_W-1:0] tid,
                         input logic [TAG_W-1:0] tag, input logic tp,
                         input logic [DATA_W-1:0] data, input logic dp);
        rd_req_vld = 1'b1; rd_req_sel = sel; rd_req_tid = tid;
        tag_src = tag; tpar_src = tp; data_src = data; dpar_src = dp;
        @(negedge rclk);
        check("rd_en", 64'(tlb_rd_en), 64'(1));
        check("rd_sel", 64'(tlb_rd_sel), 64'(sel));
        tick();
        rd_req_vld = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input logic [63:0] data,
                              input logic [TID_W-1:0] tid, input logic perr);
        bit got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge rclk);
            if (rsp_vld) got = 1'b1;
            else tick();
        end
        check({tag, "_vld"}, 64'(got), 64'(1));
        if (got) begin
            check({tag, "_data"}, rsp_data, data);
            check({tag, "_tid"}, 64'(rsp_tid), 64'(tid));
            check({tag, "_perr"}, 64'(rsp_perr), 64'(perr));
        end
        tick();
    endtask

    initial begin
        rst = 1'b1; rd_req_vld = 1'b1; rd_req_sel = 1'b0; rd_req_tid = '0;
        par_chk_en = 1'b1; rsp_rdy = 1'b1; err_cnt_clr = 1'b0;
        tick(); tick();
        @(negedge rclk);
        check("rst_rdy", 64'(rd_req_rdy), 64'(0));
        check("rst_rd_en", 64'(tlb_rd_en), 64'(0));
        check("rst_rsp_vld", 64'(rsp_vld), 64'(0));
        check("rst_rsp_data", rsp_data, 64'(0));
        check("rst_rsp_tid", 64'(rsp_tid), 64'(0));
        check("rst_rsp_perr", 64'(rsp_perr), 64'(0));
        check("rst_tag_cnt", 64'(tag_perr_cnt), 64'(0));
        check("rst_data_cnt", 64'(data_perr_cnt), 64'(0));
        check("rst_first_vld", 64'(perr_first_vld), 64'(0));
        check("rst_first_tid", 64'(perr_first_tid), 64'(0));
        tick();
        rst = 1'b0; rd_req_vld = 1'b0;
        @(negedge rclk);
        check("rdy_after_rst", 64'(rd_req_rdy), 64'(1));
        tick();

        // Data read, exact T+3 latency
        issue(1'b1, 2'd2, '0, 1'b0, 43'h1, 1'b1);
        @(negedge rclk); check("t1_lat1", 64'(rsp_vld), 64'(0)); tick();
        @(negedge rclk); check("t1_lat2", 64'(rsp_vld), 64'(0)); tick();
        @(negedge rclk);
        check("t1_vld", 64'(rsp_vld), 64'(1));
        check("t1_data", rsp_data, 64'h1);
        check("t1_tid", 64'(rsp_tid), 64'(2));
        check("t1_perr", 64'(rsp_perr), 64'(0));
        check("t1_tag_cnt", 64'(tag_perr_cnt), 64'(0));
        check("t1_data_cnt", 64'(data_perr_cnt), 64'(0));
        tick();
        @(negedge rclk);
        check("t1_empty_vld", 64'(rsp_vld), 64'(0));
        check("t1_empty_data", rsp_data, 64'(0));
        tick();

        // Tag parity error, then the same read with checking disabled
        issue(1'b0, 2'd1, 59'h3, 1'b1, '0, 1'b0);
        expect_rsp("t2a", 64'h8000_0000_0000_0003, 2'd1, 1'b1);
        check("t2a_tag_cnt", 64'(tag_perr_cnt), 64'(1));
        check("t2a_first_vld", 64'(perr_first_vld), 64'(1));
        check("t2a_first_tid", 64'(perr_first_tid), 64'(1));
        par_chk_en = 1'b0;
        issue(1'b0, 2'd1, 59'h3, 1'b1, '0, 1'b0);
        expect_rsp("t2b", 64'h3, 2'd1, 1'b0);
        par_chk_en = 1'b1;
        check("t2b_tag_cnt", 64'(tag_perr_cnt), 64'(1));

        // Later error from tid 3 must not disturb the first-error log
        issue(1'b1, 2'd3, '0, 1'b0, 43'h1, 1'b0);
        expect_rsp("t6a", 64'h8000_0000_0000_0001, 2'd3, 1'b1);
        check("t6a_first_tid", 64'(perr_first_tid), 64'(1));
        check("t6a_data_cnt", 64'(data_perr_cnt), 64'(1));

        // Five more data errors saturate the 2-bit counter
        for (int k = 0; k < 5; k++) begin
            issue(1'b1, 2'd2, '0, 1'b0, 43'h7, 1'b0);
            expect_rsp("t4", 64'h8000_0000_0000_0007, 2'd2, 1'b1);
        end
        check("t4_sat", 64'(data_perr_cnt), 64'(3));
        check("t4_tag_cnt", 64'(tag_perr_cnt), 64'(1));

        // Clear coinciding with a data-error push from tid 3
        issue(1'b1, 2'd3, '0, 1'b0, 43'h1, 1'b0);
        tick();
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        @(negedge rclk);
        check("t6b_vld", 64'(rsp_vld), 64'(1));
        check("t6b_perr", 64'(rsp_perr), 64'(1));
        check("t6b_data_cnt", 64'(data_perr_cnt), 64'(1));
        check("t6b_tag_cnt", 64'(tag_perr_cnt), 64'(0));
        check("t6b_first_vld", 64'(perr_first_vld), 64'(1));
        check("t6b_first_tid", 64'(perr_first_tid), 64'(3));
        tick();
        err_cnt_clr = 1'b1;
        tick();
        err_cnt_clr = 1'b0;
        @(negedge rclk);
        check("clr_data_cnt", 64'(data_perr_cnt), 64'(0));
        check("clr_tag_cnt", 64'(tag_perr_cnt), 64'(0));
        check("clr_first_vld", 64'(perr_first_vld), 64'(0));
        check("clr_first_tid", 64'(perr_first_tid), 64'(0));
        tick();

        // Backpressure: exactly DEPTH accepts, then in-order drain
        rsp_rdy = 1'b0; rd_req_sel = 1'b1; rd_req_tid = '0; rd_req_vld = 1'b1;
        for (int k = 0; k < 8; k++) begin
            data_src = 43'(n_acc); dpar_src = ^data_src;
            @(negedge rclk);
            if (rd_req_rdy) n_acc++;
            tick();
        end
        @(negedge rclk);
        check("t3_accepts", 64'(n_acc), 64'(4));
        check("t3_rdy_full", 64'(rd_req_rdy), 64'(0));
        check("t3_head_vld", 64'(rsp_vld), 64'(1));
        check("t3_head_data", rsp_data, 64'(0));
        tick();
        rd_req_vld = 1'b0; rsp_rdy = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge rclk);
            if (rsp_vld) begin
                check("t3_order", rsp_data, 64'(n_rsp));
                n_rsp++;
            end
            tick();
        end
        check("t3_drained", 64'(n_rsp), 64'(4));

        // Sustained one request per cycle with the consumer always ready
        for (int k = 0; k < 20; k++) begin
            rd_req_vld = (k < 12);
            data_src = 43'(n_acc); dpar_src = ^data_src;
            @(negedge rclk);
            if (rd_req_vld && rd_req_rdy) n_acc++;
            if (rsp_vld) begin
                check("t3_stream", rsp_data, 64'(n_rsp));
                n_rsp++;
            end
            tick();
        end
        check("t3_stream_acc", 64'(n_acc), 64'(16));
        check("t3_stream_rsp", 64'(n_rsp), 64'(16));

        // Reset with two requests in flight and two entries queued
        rsp_rdy = 1'b0; rd_req_vld = 1'b1; rd_req_sel = 1'b1; rd_req_tid = 2'd1;
        for (int k = 0; k < 4; k++) begin
            data_src = 43'(k + 8); dpar_src = ^data_src;
            @(negedge rclk);
            check("t5_fill_rdy", 64'(rd_req_rdy), 64'(1));
            tick();
        end
        rd_req_vld = 1'b0; rst = 1'b1;
        tick();
        rst = 1'b0; rsp_rdy = 1'b1;
        @(negedge rclk);
        check("t5_rdy_after", 64'(rd_req_rdy), 64'(1));
        check("t5_vld_after", 64'(rsp_vld), 64'(0));
        tick();
        for (int k = 0; k < 6; k++) begin
            @(negedge rclk);
            if (rsp_vld) seen++;
            tick();
        end
        check("t5_stray_rsp", 64'(seen), 64'(0));
        issue(1'b1, 2'd2, '0, 1'b0, 43'h55, 1'b0);
        @(negedge rclk); check("t5_lat1", 64'(rsp_vld), 64'(0)); tick();
        @(negedge rclk); check("t5_lat2", 64'(rsp_vld), 64'(0)); tick();
        @(negedge rclk);
        check("t5_vld", 64'(rsp_vld), 64'(1));
        check("t5_data", rsp_data, 64'h55);
        check("t5_tid", 64'(rsp_tid), 64'(2));
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
